// File: rtl/fifo_input_control.sv
// Write-side control for the 32-entry byte FIFO.
// Accepts write requests, issues a registered memory write strobe with
// address and data, and tracks occupancy from accepted writes and read-side
// pops. Byte 8'd0 is reserved as the read side's empty sentinel, so zero
// bytes are never written.
//
// Handshake: write_en/data_in are a request with no ready; the request is
// taken on a rising edge only when the FIFO is not full and the data is
// nonzero. Otherwise it is dropped and the matching sticky flag
// (overflow/bad_data) records why. rd_pop is a one-cycle pulse per completed
// read and needs no acknowledgement.
module fifo_input_control #(
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 8,
  parameter int AF_MARGIN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_pop,
  output logic              write_en_o,
  output logic [ADDR_W-1:0] ptr,
  output logic [DATA_W-1:0] data_to_mem,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              almost_full,
  output logic              overflow,
  output logic              bad_data,
  output logic [1:0]        state_dbg
);

  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AF_C      = (ADDR_W+1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_ZERO  = '0;
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   count_next;
  logic              accept;
  logic              pop_eff;

  // Flags are plain decodes of the registered count, so they cannot glitch.
  assign full        = (count == DEPTH_C);
  assign almost_full = (count >= AF_C);
  assign state_dbg   = state;

  // A write is taken only on pre-edge state; a same-cycle pop never frees room.
  assign accept  = write_en && !full && (data_in != '0);
  // Pops against an empty FIFO are ignored so count never wraps below zero.
  assign pop_eff = rd_pop && (count != CNT_ZERO);

  // Next occupancy: simultaneous accept and pop cancel out.
  always_comb begin
    count_next = count;
    if (accept && !pop_eff) begin
      count_next = count + CNT_ONE;
    end else if (!accept && pop_eff) begin
      count_next = count - CNT_ONE;
    end
  end

  // Next FSM state, decided from the next occupancy.
  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: begin
        if (accept) state_next = ST_FILLING;
      end
      ST_FILLING: begin
        if (count_next == DEPTH_C)       state_next = ST_FULL;
        else if (count_next == CNT_ZERO) state_next = ST_EMPTY;
      end
      ST_FULL: begin
        if (rd_pop) state_next = ST_FILLING;
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_EMPTY;
    else        state <= state_next;
  end

  // Occupancy counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count <= '0;
    else        count <= count_next;
  end

  // Write strobe, address and data: one cycle after acceptance; address and
  // data hold their last values while the strobe is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_en_o  <= 1'b0;
      ptr         <= '0;
      data_to_mem <= '0;
      wr_ptr      <= '0;
    end else begin
      write_en_o <= accept;
      if (accept) begin
        ptr         <= wr_ptr;
        data_to_mem <= data_in;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
    end
  end

  // Sticky reject flags; any accepted write clears both. A full FIFO takes
  // precedence over zero data so only overflow is raised in that case.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      bad_data <= 1'b0;
    end else if (accept) begin
      overflow <= 1'b0;
      bad_data <= 1'b0;
    end else begin
      if (write_en && full)                        overflow <= 1'b1;
      if (write_en && !full && (data_in == '0))    bad_data <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_input_control.sv
// Bench for fifo_input_control: directed scenarios followed by randomized
// traffic, every cycle checked against a queue-based occupancy model.
module tb_fifo_input_control;

  localparam int DEPTH = 32;
  localparam int AF    = 28;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       write_en = 1'b0;
  logic [7:0] data_in  = 8'h00;
  logic       rd_pop   = 1'b0;
  logic       write_en_o;
  logic [4:0] ptr;
  logic [7:0] data_to_mem;
  logic [5:0] count;
  logic       full, almost_full, overflow, bad_data;
  logic [1:0] state_dbg;

  fifo_input_control dut (
    .clk         (clk),
    .reset       (reset),
    .write_en    (write_en),
    .data_in     (data_in),
    .rd_pop      (rd_pop),
    .write_en_o  (write_en_o),
    .ptr         (ptr),
    .data_to_mem (data_to_mem),
    .count       (count),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow),
    .bad_data    (bad_data),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard / model ----------------
  logic [7:0] exp_q[$];   // bytes currently held in the FIFO
  int         m_wr_ptr;
  logic       m_we;
  logic [4:0] m_ptr;
  logic [7:0] m_data;
  logic       m_ovf;
  logic       m_bad;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_state(input int n);
    if (n == 0)     return 2'd0;
    if (n == DEPTH) return 2'd2;
    return 2'd1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_wr_ptr = 0;
    m_we     = 1'b0;
    m_ptr    = '0;
    m_data   = '0;
    m_ovf    = 1'b0;
    m_bad    = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = exp_q.size();
    chk({tag, "_we_o"},  32'(write_en_o),  32'(m_we));
    chk({tag, "_ptr"},   32'(ptr),         32'(m_ptr));
    chk({tag, "_data"},  32'(data_to_mem), 32'(m_data));
    chk({tag, "_count"}, 32'(count),       32'(n));
    chk({tag, "_full"},  32'(full),        32'(n == DEPTH));
    chk({tag, "_afull"}, 32'(almost_full), 32'(n >= AF));
    chk({tag, "_ovf"},   32'(overflow),    32'(m_ovf));
    chk({tag, "_bad"},   32'(bad_data),    32'(m_bad));
    chk({tag, "_state"}, 32'(state_dbg),   32'(exp_state(n)));
  endtask

  // ---------------- driver tasks ----------------
  // Applies one cycle of inputs, advances the model by the same cycle, then
  // checks all outputs 1 time unit after the edge.
  task automatic drive(input string tag, input logic we, input logic [7:0] d, input logic pop);
    int n;
    logic acc;
    write_en = we;
    data_in  = d;
    rd_pop   = pop;
    n   = exp_q.size();
    acc = we && (n != DEPTH) && (d != 8'h00);
    m_we = acc;
    if (acc) begin
      m_ptr    = 5'(m_wr_ptr);
      m_data   = d;
      m_wr_ptr = (m_wr_ptr + 1) % DEPTH;
      m_ovf    = 1'b0;
      m_bad    = 1'b0;
    end else begin
      if (we && n == DEPTH)                m_ovf = 1'b1;
      if (we && n != DEPTH && d == 8'h00)  m_bad = 1'b1;
    end
    if (pop && n > 0) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(d);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    write_en = 1'b0;
    data_in  = 8'h00;
    rd_pop   = 1'b0;
  endtask

  // Pulls reset low between edges, checks outputs clear before the next
  // edge, holds through one edge, then releases away from the edge.
  task automatic async_reset(input string tag);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_all({tag, "_async"});
    idle_inputs();
    @(posedge clk);
    #1;
    check_all({tag, "_held"});
    reset = 1'b1;
  endtask

  task automatic fill(input string tag, input int k);
    for (int i = 0; i < k; i++) drive(tag, 1'b1, 8'(8'h20 + i), 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int thr_w, thr_p;
    logic we_r, pop_r;
    logic [7:0] d_r;

    model_reset();
    #1;
    check_all("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // 1: four consecutive writes
    drive("t1a", 1'b1, 8'h11, 1'b0);
    chk("t1_ptr0", 32'(ptr), 32'd0);
    drive("t1b", 1'b1, 8'h12, 1'b0);
    drive("t1c", 1'b1, 8'h13, 1'b0);
    drive("t1d", 1'b1, 8'h14, 1'b0);
    chk("t1_ptr3",  32'(ptr),         32'd3);
    chk("t1_data3", 32'(data_to_mem), 32'h14);
    drive("t1e", 1'b0, 8'h00, 1'b0);
    chk("t1_count", 32'(count), 32'd4);
    chk("t1_we_lo", 32'(write_en_o), 32'd0);

    // 2: fill to full, then one more write
    async_reset("t2r");
    fill("t2f", 28);
    chk("t2_afull28", 32'(almost_full), 32'd1);
    fill("t2g", 4);
    chk("t2_full", 32'(full), 32'd1);
    drive("t2x", 1'b1, 8'hAA, 1'b0);
    chk("t2_nostrobe", 32'(write_en_o), 32'd0);
    chk("t2_ovf",      32'(overflow),   32'd1);
    chk("t2_count",    32'(count),      32'd32);

    // full + write + pop together: write still rejected
    drive("t2y", 1'b1, 8'hBB, 1'b1);
    chk("t2_nobypass", 32'(write_en_o), 32'd0);
    chk("t2y_count",   32'(count),      32'd31);
    drive("t2z", 1'b1, 8'hCC, 1'b0);  // refill to 32 at ptr 0
    drive("t2w", 1'b1, 8'h00, 1'b0);  // full and zero: only overflow
    chk("t2w_ovf", 32'(overflow), 32'd1);
    chk("t2w_bad", 32'(bad_data), 32'd0);

    // 3: pop from full, then a write wraps to ptr 0
    async_reset("t3r");
    fill("t3f", 32);
    drive("t3x", 1'b1, 8'hAA, 1'b0);
    drive("t3p", 1'b0, 8'h00, 1'b1);
    chk("t3_full_drop", 32'(full),  32'd0);
    chk("t3_count31",   32'(count), 32'd31);
    drive("t3w", 1'b1, 8'h55, 1'b0);
    chk("t3_wrap_ptr", 32'(ptr),      32'd0);
    chk("t3_ovf_clr",  32'(overflow), 32'd0);
    chk("t3_count32",  32'(count),    32'd32);

    // 4: write and pop in the same cycle at count 10
    async_reset("t4r");
    fill("t4f", 10);
    drive("t4x", 1'b1, 8'h7E, 1'b1);
    chk("t4_ptr",   32'(ptr),        32'd10);
    chk("t4_we",    32'(write_en_o), 32'd1);
    chk("t4_count", 32'(count),      32'd10);

    // 5: zero byte rejected, then cleared by a good write
    async_reset("t5r");
    fill("t5f", 3);
    drive("t5z", 1'b1, 8'h00, 1'b0);
    chk("t5_bad",   32'(bad_data),   32'd1);
    chk("t5_nostb", 32'(write_en_o), 32'd0);
    chk("t5_count", 32'(count),      32'd3);
    drive("t5w", 1'b1, 8'h01, 1'b0);
    chk("t5_bad_clr", 32'(bad_data), 32'd0);

    // pop on empty is ignored
    async_reset("t5e");
    drive("t5pe", 1'b0, 8'h00, 1'b1);
    chk("t5_empty_pop", 32'(count), 32'd0);

    // 6: asynchronous reset mid-burst
    fill("t6f", 5);
    async_reset("t6r");

    // randomized traffic in alternating fill-heavy / drain-heavy phases
    for (int p = 0; p < 8; p++) begin
      thr_w = (p % 2 == 0) ? 85 : 30;
      thr_p = (p % 2 == 0) ? 20 : 70;
      for (int i = 0; i < 200; i++) begin
        we_r  = ($urandom_range(0, 99) < thr_w);
        pop_r = ($urandom_range(0, 99) < thr_p);
        d_r   = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        drive("rnd", we_r, d_r, pop_r);
      end
    end
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
